tlut_prod_drain: RTL

Downstream stage of the temporal-LUT SIMD cell. It samples the cell's registered product array at the end of every temporal window and accumulates `NUM_WIN` windows to reduce over the shared `DIM_B` dimension. Each completed result tile moves into a drain buffer. The buffer is serialized one element per cycle over a valid/ready stream to the output writer.

---
 rtl/tlut_prod_drain.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tlut_prod_drain.sv
// Window accumulator and drain serializer behind the temporal-LUT SIMD cell.
// Sums NUM_WIN captured product tiles, then streams the result row-major over valid/ready.
module tlut_prod_drain #(
    parameter int DIM_A     = 4,
    parameter int DIM_C     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int NUM_WIN   = 4,
    parameter int OUT_WIDTH = ACC_WIDTH + $clog2(NUM_WIN + 1),
    localparam int RW = (DIM_C > 1) ? $clog2(DIM_C) : 1,
    localparam int CW = (DIM_A > 1) ? $clog2(DIM_A) : 1,
    localparam int WW = $clog2(NUM_WIN + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             rollover,
    input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0] product_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [RW-1:0]                    out_row,
    output logic [CW-1:0]                    out_col,
    output logic                             out_last,
    output logic [WW-1:0]                    win_cnt,
    output logic                             overrun
);
    localparam int N  = DIM_C * DIM_A;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_DRAIN = 1'b1;

    logic                 cap_d1_q, cap_d1_d;
    logic                 cap_d2_q, cap_d2_d;
    logic [WW-1:0]        win_cnt_q, win_cnt_d;
    logic [OUT_WIDTH-1:0] acc_q [N];
    logic [OUT_WIDTH-1:0] acc_d [N];
    logic [OUT_WIDTH-1:0] buf_q [N];
    logic [OUT_WIDTH-1:0] buf_d [N];
    logic [OUT_WIDTH-1:0] sum   [N];
    logic [0:0]           state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 overrun_q, overrun_d;

    logic          tile_done;
    logic          last_idx;
    logic          final_hs;
    logic          load;
    logic [IW-1:0] idx;

    always_comb begin
        cap_d1_d  = rollover & enable;
        cap_d2_d  = cap_d1_q;
        win_cnt_d = win_cnt_q;
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        for (int i = 0; i < N; i++) begin
            sum[i]   = acc_q[i] + OUT_WIDTH'(product_in[i*ACC_WIDTH +: ACC_WIDTH]);
            acc_d[i] = acc_q[i];
            buf_d[i] = buf_q[i];
        end

        tile_done = cap_d2_q && (win_cnt_q == WW'(NUM_WIN - 1));
        last_idx  = (row_q == RW'(DIM_C - 1)) && (col_q == CW'(DIM_A - 1));
        final_hs  = (state_q == STATE_DRAIN) && out_ready && last_idx;
        // The final handshake frees the buffer in the same cycle, so a new tile may load there.
        load      = tile_done && ((state_q == STATE_IDLE) || final_hs);

        if (cap_d2_q) begin
            if (tile_done) begin
                win_cnt_d = '0;
                for (int i = 0; i < N; i++) acc_d[i] = '0;
            end else begin
                win_cnt_d = win_cnt_q + WW'(1);
                for (int i = 0; i < N; i++) acc_d[i] = sum[i];
            end
        end

        if (load) begin
            state_d = STATE_DRAIN;
            row_d   = '0;
            col_d   = '0;
            for (int i = 0; i < N; i++) buf_d[i] = sum[i];
        end else if ((state_q == STATE_DRAIN) && out_ready) begin
            if (last_idx) begin
                state_d = STATE_IDLE;
                row_d   = '0;
                col_d   = '0;
            end else if (col_q == CW'(DIM_A - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (tile_done && !load) overrun_d = 1'b1;

        idx = IW'(row_q) * IW'(DIM_A) + IW'(col_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_d1_q  <= 1'b0;
            cap_d2_q  <= 1'b0;
            win_cnt_q <= '0;
            state_q   <= STATE_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
                buf_q[i] <= '0;
            end
        end else begin
            cap_d1_q  <= cap_d1_d;
            cap_d2_q  <= cap_d2_d;
            win_cnt_q <= win_cnt_d;
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= acc_d[i];
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign out_valid = (state_q == STATE_DRAIN);
    assign out_last  = (state_q == STATE_DRAIN) && last_idx;
    assign out_data  = buf_q[idx];
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign win_cnt   = win_cnt_q;
    assign overrun   = overrun_q;
endmodule
